// File: rtl/mips_mdu_pkg.sv
// Shared types and constants for the MIPS iterative multiply/divide unit.
package mips_mdu_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } mdu_state_t;

  localparam int MDU_ITER = 32;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate: y = neg ? -a : a.
module mdu_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + 1'b1) : a;

endmodule

// File: rtl/muldivunit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one radix-2 multiply
// step or one restoring-divide step per cycle on operand magnitudes.
module muldivunit
  import mips_mdu_pkg::*;
#(
  parameter int WIDTH = MDU_ITER
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             mthiE,
  input  logic             mtloE,
  input  logic             killE,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  // Handshake: startE/mthiE/mtloE are accepted only in IDLE (busy low, which
  // includes the cycle done is high); killE aborts an in-flight op and masks
  // any request in the same IDLE cycle. done pulses once per result written.

  localparam int CW = $clog2(WIDTH);

  mdu_state_t state, stateNext;
  mdu_op_t    op;

  logic [CW-1:0]      cnt;
  logic               opDiv;
  logic               negQ;
  logic               negR;
  logic [WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0] acc;

  logic               signedOp;
  logic               isDiv;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;

  logic [2*WIDTH-1:0] mulAcc;
  logic [2*WIDTH-1:0] divAcc;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divHi;
  logic [WIDTH-1:0]   divDiff;
  logic               divGe;

  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;

  assign op       = mdu_op_t'(opE);
  assign signedOp = (op == MULT) || (op == DIV);
  assign isDiv    = (op == DIV) || (op == DIVU);

  mdu_negate #(.W(WIDTH)) uAbsA (.neg(signedOp & srcaE[WIDTH-1]), .a(srcaE), .y(absA));
  mdu_negate #(.W(WIDTH)) uAbsB (.neg(signedOp & srcbE[WIDTH-1]), .a(srcbE), .y(absB));

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  assign mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign mulAcc = acc[0] ? {mulSum, acc[WIDTH-1:1]}
                         : {1'b0, acc[2*WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left.
  assign divHi   = acc[2*WIDTH-1:WIDTH-1];
  assign divGe   = divHi >= {1'b0, addend};
  assign divDiff = divHi[WIDTH-1:0] - addend;
  assign divAcc  = divGe ? {divDiff, acc[WIDTH-2:0], 1'b1}
                         : {acc[2*WIDTH-2:0], 1'b0};

  mdu_negate #(.W(2*WIDTH)) uFixP (.neg(negQ), .a(acc), .y(prodFix));
  mdu_negate #(.W(WIDTH)) uFixQ (.neg(negQ), .a(acc[WIDTH-1:0]), .y(quoFix));
  mdu_negate #(.W(WIDTH)) uFixR (.neg(negR), .a(acc[2*WIDTH-1:WIDTH]), .y(remFix));

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (startE && !killE) stateNext = CALC;
      CALC: begin
        if (killE)            stateNext = IDLE;
        else if (cnt == '0)   stateNext = FIX;
      end
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      opDiv  <= 1'b0;
      negQ   <= 1'b0;
      negR   <= 1'b0;
      addend <= '0;
      acc    <= '0;
    end else begin
      busy <= (stateNext != IDLE);
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!killE && startE) begin
            cnt   <= CW'(WIDTH - 1);
            opDiv <= isDiv;
            // A zero divisor keeps the all-ones quotient unsigned-looking.
            negQ  <= signedOp & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]) & (srcbE != '0);
            negR  <= signedOp & srcaE[WIDTH-1];
            if (isDiv) begin
              addend <= absB;
              acc    <= {{WIDTH{1'b0}}, absA};
            end else begin
              addend <= absA;
              acc    <= {{WIDTH{1'b0}}, absB};
            end
          end else if (!killE) begin
            if (mthiE) hi <= srcaE;
            if (mtloE) lo <= srcaE;
          end
        end
        CALC: begin
          if (!killE) begin
            acc <= opDiv ? divAcc : mulAcc;
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          if (!killE) begin
            if (opDiv) begin
              hi <= remFix;
              lo <= quoFix;
            end else begin
              {hi, lo} <= prodFix;
            end
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
